// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one simple_mem port. A granted
// transfer that sees no s_mem_ready for TIMEOUT_CYCLES cycles is force-completed.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBADC0DE5
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,

  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;

  logic        granted;
  logic        gnt_sel;
  logic        gnt_valid;
  logic        complete;
  logic        timeout;
  logic        done;
  logic [31:0] done_data;

  always_comb begin
    granted   = (state_q == GNT0) || (state_q == GNT1);
    gnt_sel   = (state_q == GNT1);
    gnt_valid = granted && (gnt_sel ? m1_mem_valid : m0_mem_valid);
    complete  = gnt_valid && s_mem_ready;
    // A real ready in the last allowed cycle is a normal completion, not a timeout.
    timeout   = gnt_valid && !s_mem_ready && (cnt_q == CNT_LAST);
    done      = complete || timeout;
    done_data = timeout ? ERR_DATA : s_mem_rdata;
  end

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    timeout_err  = timeout;

    if (granted) begin
      s_mem_valid = gnt_valid && !timeout;
      s_mem_instr = gnt_sel ? m1_mem_instr : m0_mem_instr;
      s_mem_addr  = gnt_sel ? m1_mem_addr  : m0_mem_addr;
      s_mem_wdata = gnt_sel ? m1_mem_wdata : m0_mem_wdata;
      s_mem_wstrb = gnt_sel ? m1_mem_wstrb : m0_mem_wstrb;
    end

    if (done && !gnt_sel) begin
      m0_mem_ready = 1'b1;
      m0_mem_rdata = done_data;
    end
    if (done && gnt_sel) begin
      m1_mem_ready = 1'b1;
      m1_mem_rdata = done_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_mem_valid && m1_mem_valid) state_d = last_grant_q ? GNT0 : GNT1;
        else if (m0_mem_valid)            state_d = GNT0;
        else if (m1_mem_valid)            state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!gnt_valid) begin
          // Requester withdrew: give up the slot without touching fairness history.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d      = IDLE;
          last_grant_d = gnt_sel;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hBADC0DE5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_mem_valid = 1'b0, m0_mem_instr = 1'b0;
  logic [31:0] m0_mem_addr = '0, m0_mem_wdata = '0;
  logic [3:0]  m0_mem_wstrb = '0;
  logic        m0_mem_ready;
  logic [31:0] m0_mem_rdata;
  logic        m1_mem_valid = 1'b0, m1_mem_instr = 1'b0;
  logic [31:0] m1_mem_addr = '0, m1_mem_wdata = '0;
  logic [3:0]  m1_mem_wstrb = '0;
  logic        m1_mem_ready;
  logic [31:0] m1_mem_rdata;
  logic        s_mem_valid, s_mem_instr;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_mem_ready = 1'b0;
  logic [31:0] s_mem_rdata;
  logic        timeout_err;

  logic [31:0] mem [0:1023];
  assign s_mem_rdata = mem[s_mem_addr[11:2]];

  int n_tests = 0;
  int n_fail  = 0;

  int mdl_owner = -1;
  int mdl_n     = 0;
  bit mdl_last  = 1'b1;
  bit done_q [2];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic valid_of(int x);
    return (x == 1) ? m1_mem_valid : m0_mem_valid;
  endfunction
  function automatic logic instr_of(int x);
    return (x == 1) ? m1_mem_instr : m0_mem_instr;
  endfunction
  function automatic logic [31:0] addr_of(int x);
    return (x == 1) ? m1_mem_addr : m0_mem_addr;
  endfunction
  function automatic logic [31:0] wdata_of(int x);
    return (x == 1) ? m1_mem_wdata : m0_mem_wdata;
  endfunction
  function automatic logic [3:0] wstrb_of(int x);
    return (x == 1) ? m1_mem_wstrb : m0_mem_wstrb;
  endfunction

  // Transaction-level reference: who owns the port, which granted cycle this is,
  // and who was served last. Outputs follow directly from those three facts.
  initial begin : model
    int nxt, x;
    bit v, to_hit, fin;
    logic [31:0] a;
    logic e_sv, e_si, e_to;
    logic [31:0] e_sa, e_sd;
    logic [3:0] e_ss;
    logic e_r [2];
    logic [31:0] e_d [2];
    bit chk_d [2];
    bit chk_f, wr_pend;
    logic [31:0] wr_data;
    logic [3:0] wr_strb;
    logic [9:0] wr_idx;
    forever begin
      @(negedge clk);
      e_sv = 1'b0; e_si = 1'b0; e_sa = '0; e_sd = '0; e_ss = '0; e_to = 1'b0;
      e_r[0] = 1'b0; e_r[1] = 1'b0; e_d[0] = '0; e_d[1] = '0;
      chk_d[0] = 1'b1; chk_d[1] = 1'b1; chk_f = 1'b1; wr_pend = 1'b0;
      wr_data = '0; wr_strb = '0; wr_idx = '0;
      nxt = -1;
      if (!resetn) begin
        mdl_owner = -1; mdl_n = 0; mdl_last = 1'b1;
      end else if (mdl_owner < 0) begin
        if (m0_mem_valid && m1_mem_valid) nxt = mdl_last ? 0 : 1;
        else if (m0_mem_valid)            nxt = 0;
        else if (m1_mem_valid)            nxt = 1;
      end else begin
        x      = mdl_owner;
        v      = valid_of(x);
        e_si   = instr_of(x);
        e_sa   = addr_of(x);
        e_sd   = wdata_of(x);
        e_ss   = wstrb_of(x);
        to_hit = v && !s_mem_ready && (mdl_n == int'(TO));
        fin    = v && (s_mem_ready || to_hit);
        e_sv   = v && !to_hit;
        chk_f  = !to_hit;
        chk_d[x] = fin;
        if (fin) begin
          e_r[x]   = 1'b1;
          mdl_last = (x == 1);
          if (to_hit) begin
            e_d[x] = ERR;
            e_to   = 1'b1;
          end else begin
            a      = e_sa;
            e_d[x] = mem[a[11:2]];
            if (e_ss != 4'b0) begin
              wr_pend = 1'b1; wr_data = e_sd; wr_strb = e_ss; wr_idx = a[11:2];
            end
          end
        end else if (v) begin
          nxt = x;
        end
      end

      check("s_mem_valid", 32'(s_mem_valid), 32'(e_sv));
      if (chk_f) begin
        check("s_mem_instr", 32'(s_mem_instr), 32'(e_si));
        check("s_mem_addr", s_mem_addr, e_sa);
        check("s_mem_wdata", s_mem_wdata, e_sd);
        check("s_mem_wstrb", 32'(s_mem_wstrb), 32'(e_ss));
      end
      check("m0_mem_ready", 32'(m0_mem_ready), 32'(e_r[0]));
      check("m1_mem_ready", 32'(m1_mem_ready), 32'(e_r[1]));
      if (chk_d[0]) check("m0_mem_rdata", m0_mem_rdata, e_d[0]);
      if (chk_d[1]) check("m1_mem_rdata", m1_mem_rdata, e_d[1]);
      check("timeout_err", 32'(timeout_err), 32'(e_to));
      done_q[0] = e_r[0];
      done_q[1] = e_r[1];

      @(posedge clk);
      if (wr_pend)
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mem[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      if (nxt < 0)               mdl_n = 0;
      else if (nxt == mdl_owner) mdl_n++;
      else                       mdl_n = 1;
      mdl_owner = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int x, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
    if (x == 1) begin
      m1_mem_valid = 1'b1; m1_mem_addr = a; m1_mem_wdata = d; m1_mem_wstrb = s; m1_mem_instr = ins;
    end else begin
      m0_mem_valid = 1'b1; m0_mem_addr = a; m0_mem_wdata = d; m0_mem_wstrb = s; m0_mem_instr = ins;
    end
  endtask

  task automatic rand_req(input int x);
    set_req(x, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle_all();
    m0_mem_valid = 1'b0;
    m1_mem_valid = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] seq;
    int thresh;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Reset with both requesters already pending; then the tie sequence.
    set_req(0, 32'h0000_0100, 32'h1111_0000, 4'h0, 1'b0);
    set_req(1, 32'h0000_0200, 32'h2222_0000, 4'h0, 1'b1);
    s_mem_ready = 1'b1;
    @(negedge clk);
    check("rst s_mem_valid", 32'(s_mem_valid), 32'h0);
    check("rst m0_mem_ready", 32'(m0_mem_ready), 32'h0);
    check("rst m1_mem_ready", 32'(m1_mem_ready), 32'h0);
    check("rst s_mem_addr", s_mem_addr, 32'h0);
    check("rst m0_mem_rdata", m0_mem_rdata, 32'h0);
    check("rst timeout_err", 32'(timeout_err), 32'h0);
    tick();
    resetn = 1'b1;

    seq = '0;
    repeat (8) begin
      @(negedge clk);
      if (m0_mem_ready || m1_mem_ready)
        seq = (seq << 4) | {30'b0, m1_mem_ready, m0_mem_ready};
      tick();
    end
    check("tie order m0,m1,m0,m1", seq, 32'h0000_1212);
    idle_all();

    // Single write then readback of the same word.
    set_req(0, 32'h0001_0000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    @(negedge clk);
    check("wr idle s_mem_valid", 32'(s_mem_valid), 32'h0);
    tick();
    @(negedge clk);
    check("wr s_mem_valid", 32'(s_mem_valid), 32'h1);
    check("wr m0_mem_ready", 32'(m0_mem_ready), 32'h1);
    check("wr s_mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
    check("wr s_mem_wstrb", 32'(s_mem_wstrb), 32'hF);
    tick();
    m0_mem_valid = 1'b0;
    @(negedge clk);
    tick();
    set_req(0, 32'h0001_0000, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rd m0_mem_ready", 32'(m0_mem_ready), 32'h1);
    check("rd m0_mem_rdata", m0_mem_rdata, 32'hDEAD_BEEF);
    tick();
    m0_mem_valid = 1'b0;

    // m1 aborts inside GNT1; fairness must still favour m1 afterwards.
    s_mem_ready = 1'b0;
    set_req(1, 32'h0000_0300, 32'h3333_3333, 4'h0, 1'b0);
    @(negedge clk);
    tick();
    m1_mem_valid = 1'b0;
    @(negedge clk);
    check("abort m1_mem_ready", 32'(m1_mem_ready), 32'h0);
    check("abort s_mem_valid", 32'(s_mem_valid), 32'h0);
    tick();
    set_req(0, 32'h0000_0310, 32'h0, 4'h0, 1'b0);
    set_req(1, 32'h0000_0320, 32'h0, 4'h0, 1'b0);
    s_mem_ready = 1'b1;
    @(negedge clk);
    check("abort idle m1_mem_ready", 32'(m1_mem_ready), 32'h0);
    tick();
    @(negedge clk);
    check("abort keeps last m1_ready", 32'(m1_mem_ready), 32'h1);
    check("abort keeps last m0_ready", 32'(m0_mem_ready), 32'h0);
    tick();
    idle_all();

    // m1 held off while m0 is stalled; ready lands on the last allowed cycle.
    s_mem_ready = 1'b0;
    set_req(0, 32'h0000_0400, 32'h4444_4444, 4'b0011, 1'b1);
    @(negedge clk);
    tick();
    set_req(1, 32'h0000_0500, 32'h5555_5555, 4'b1100, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("hold m0_mem_ready", 32'(m0_mem_ready), 32'h0);
      check("hold m1_mem_ready", 32'(m1_mem_ready), 32'h0);
      check("hold s_mem_addr", s_mem_addr, 32'h0000_0400);
      tick();
    end
    s_mem_ready = 1'b1;
    @(negedge clk);
    check("late ready m0_mem_ready", 32'(m0_mem_ready), 32'h1);
    check("late ready timeout_err", 32'(timeout_err), 32'h0);
    check("late ready s_mem_valid", 32'(s_mem_valid), 32'h1);
    tick();
    m0_mem_valid = 1'b0;
    @(negedge clk);
    check("hold idle s_mem_valid", 32'(s_mem_valid), 32'h0);
    tick();
    @(negedge clk);
    check("hold m1 s_mem_addr", s_mem_addr, 32'h0000_0500);
    check("hold m1_mem_ready", 32'(m1_mem_ready), 32'h1);
    tick();
    idle_all();

    // Timeout on the 4th granted cycle.
    s_mem_ready = 1'b0;
    set_req(0, 32'h0000_0600, 32'h6666_6666, 4'h0, 1'b0);
    @(negedge clk);
    tick();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("to wait m0_mem_ready", 32'(m0_mem_ready), 32'h0);
      check("to wait timeout_err", 32'(timeout_err), 32'h0);
      tick();
    end
    @(negedge clk);
    check("to m0_mem_ready", 32'(m0_mem_ready), 32'h1);
    check("to m0_mem_rdata", m0_mem_rdata, 32'hBADC_0DE5);
    check("to timeout_err", 32'(timeout_err), 32'h1);
    check("to s_mem_valid", 32'(s_mem_valid), 32'h0);
    tick();
    m0_mem_valid = 1'b0;
    @(negedge clk);
    check("to idle timeout_err", 32'(timeout_err), 32'h0);
    tick();

    // Reset during a stalled GNT1; m0 must win the tie afterwards.
    set_req(1, 32'h0000_0700, 32'h7777_7777, 4'hF, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("pre-rst s_mem_valid", 32'(s_mem_valid), 32'h1);
    tick();
    resetn = 1'b0;
    #1;
    check("async rst s_mem_valid", 32'(s_mem_valid), 32'h0);
    check("async rst s_mem_addr", s_mem_addr, 32'h0);
    check("async rst s_mem_wstrb", 32'(s_mem_wstrb), 32'h0);
    check("async rst m1_mem_ready", 32'(m1_mem_ready), 32'h0);
    set_req(0, 32'h0000_0800, 32'h8888_8888, 4'h0, 1'b0);
    @(negedge clk);
    tick();
    resetn = 1'b1;
    s_mem_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("post-rst m0_mem_ready", 32'(m0_mem_ready), 32'h1);
    check("post-rst m1_mem_ready", 32'(m1_mem_ready), 32'h0);
    check("post-rst s_mem_addr", s_mem_addr, 32'h0000_0800);
    tick();
    idle_all();

    // Randomized traffic; the model process checks every cycle.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      thresh = ((cyc / 250) % 5) * 2 + 1;
      s_mem_ready = ($urandom_range(0, 9) < thresh);
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 399) == 0) resetn = 1'b0;
      for (int x = 0; x < 2; x++) begin
        if (valid_of(x)) begin
          if (done_q[x] && $urandom_range(0, 3) == 0) rand_req(x);
          else if (done_q[x] || $urandom_range(0, 15) == 0) begin
            if (x == 1) m1_mem_valid = 1'b0;
            else        m0_mem_valid = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(x);
        end
      end
      tick();
    end
    idle_all();
    @(negedge clk);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
